pipeline_stall_sequencer: RTL and testbench
===========================================

Name: pipeline_stall_sequencer

Overview:
- Sequences pipeline-register enables for the 5-stage MIPS core from hazard classifications produced in ID.
- Converts each hazard class into a fixed-length stall, inserts ID/EX bubbles, and flushes IF/ID on taken branch/jump.
- Freezes the whole front end on an external memory hold.
- Sits between the hazard-detection logic and the PC / IF/ID / ID/EX registers. Keeps saturating stall and flush counters for performance analysis.

Parameters:
- CNT_W, 16, width of the stall-cycle and flush performance counters.
- STALL_W, 2, width of the internal stall-remaining counter; must hold the maximum stall length of 2.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous, active-high reset.
- ext_hold  in  1  memory not ready; freeze PC, IF/ID and ID/EX.
- hz_load_use  in  1  load in EX feeds an ID operand; needs a 1-cycle stall.
- hz_br_alu  in  1  ID branch depends on an EX ALU result; needs a 1-cycle stall.
- hz_br_ld_ex  in  1  ID branch depends on a load in EX; needs a 2-cycle stall.
- hz_br_ld_mem  in  1  ID branch depends on a load in MEM; needs a 1-cycle stall.
- redirect  in  1  ID resolved a taken branch or jump.
- perf_clr  in  1  synchronous clear of both performance counters.
- pc_write_en  out  1  1 = PC loads its next value.
- ifid_write_en  out  1  1 = IF/ID loads.
- ifid_flush  out  1  1 = IF/ID loads a NOP.
- idex_write_en  out  1  1 = ID/EX loads.
- idex_bubble  out  1  1 = ID/EX loads zeroed control.
- busy  out  1  1 while in STALL state.
- stall_cycles  out  CNT_W  count of bubble cycles inserted.
- flush_count  out  CNT_W  count of IF/ID flushes.

Behaviour:
- Enables are active-high. The sequencer does not use inverted "stall" polarity.
- Reset (rst=1 at posedge):
  - state=RUN, remaining=0, stall_cycles=0, flush_count=0.
  - While rst=1, all enables, flush, bubble and busy are 0.
- States: RUN and STALL.
- Stall length:
  - len = max over asserted hazards: hz_br_ld_ex→2; hz_load_use / hz_br_alu / hz_br_ld_mem→1; none→0.
  - Simultaneous hazards take the maximum, never the sum.
- Priority each cycle: ext_hold > active stall > new hazard > redirect > normal.
- ext_hold=1 (any state):
  - pc_write_en=ifid_write_en=idex_write_en=0, idex_bubble=0, ifid_flush=0.
  - State and remaining unchanged; hazard and redirect inputs ignored; counters unchanged.
- RUN, no hold, len>0 (Mealy, same cycle):
  - pc_write_en=0, ifid_write_en=0, idex_write_en=1, idex_bubble=1.
  - If len=2: remaining←1, go to STALL. Otherwise stay in RUN.
  - A redirect in the same cycle is ignored; ID re-presents the branch after the stall.
- RUN, no hold, len=0:
  - All enables 1, idex_bubble=0.
  - ifid_flush=redirect; when redirect=1, PC takes the target and IF/ID loads a NOP.
- STALL, no hold:
  - Same outputs as a stall cycle; busy=1; hazard and redirect inputs ignored.
  - remaining decrements; when remaining reaches 0, go to RUN on the next edge.
- Latency: a hazard of length N gives exactly N consecutive bubble cycles, excluding hold cycles. The instruction in ID advances on cycle N+1.
- Counters:
  - stall_cycles +1 on every cycle with idex_bubble=1; flush_count +1 on every cycle with ifid_flush=1.
  - Both saturate at 2^CNT_W−1 and do not wrap.
  - perf_clr takes priority over an increment in the same cycle.
- Reset mid-stall: returns to RUN with remaining=0 and no residual bubbles.

Decomposition:
- Shared package pipe_ctrl_pkg holds:
  - state enum {RUN, STALL};
  - constants LU_STALL=1, BR_ALU_STALL=1, BR_LD_EX_STALL=2, BR_LD_MEM_STALL=1.
- Sub-module sat_counter (parameter W; inputs clk, rst, clr, inc; output count) is instantiated twice for the performance counters.

Test Plan:
- hz_load_use=1 for 1 cycle in RUN → that cycle pc_write_en=0, ifid_write_en=0, idex_bubble=1; next cycle all enables 1; stall_cycles=1.
- hz_br_ld_ex=1 together with hz_br_alu=1 → exactly 2 bubble cycles (not 3); busy=1 in the second; stall_cycles=2.
- redirect=1 with no hazard → ifid_flush=1 and pc_write_en=1 for one cycle; flush_count=1. redirect=1 together with hz_br_alu=1 → ifid_flush=0 and one bubble.
- hz_br_ld_ex at cycle 0 and ext_hold=1 in cycle 1 → cycle 1 has all enables 0 and bubble 0; bubbles occur in cycles 0 and 2; RUN resumes in cycle 3; stall_cycles=2.
- rst asserted during STALL → next cycle state=RUN, all counters 0. With CNT_W=4, 20 load-use stalls → stall_cycles holds at 15. perf_clr together with a bubble → counter reads 0.

Source files
------------

// File: rtl/pipe_ctrl_pkg.sv
// Shared types and stall-length constants for the pipeline stall sequencer.
package pipe_ctrl_pkg;

  typedef enum logic [0:0] {
    RUN   = 1'b0,
    STALL = 1'b1
  } state_t;

  localparam int unsigned LU_STALL        = 1;
  localparam int unsigned BR_ALU_STALL    = 1;
  localparam int unsigned BR_LD_EX_STALL  = 2;
  localparam int unsigned BR_LD_MEM_STALL = 1;

  // Longest stall demanded by the asserted hazards; concurrent hazards overlap.
  function automatic int unsigned stall_len(input logic load_use,
                                            input logic br_alu,
                                            input logic br_ld_ex,
                                            input logic br_ld_mem);
    int unsigned len;
    len = 0;
    if (load_use  && (LU_STALL        > len)) len = LU_STALL;
    if (br_alu    && (BR_ALU_STALL    > len)) len = BR_ALU_STALL;
    if (br_ld_ex  && (BR_LD_EX_STALL  > len)) len = BR_LD_EX_STALL;
    if (br_ld_mem && (BR_LD_MEM_STALL > len)) len = BR_LD_MEM_STALL;
    return len;
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous reset and clear.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         inc,
  output logic [W-1:0] count
);

  logic [W-1:0] r_count;

  // Clear wins over increment; hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {W{1'b1}})) begin
      r_count <= r_count + W'(1);
    end
  end

  assign count = r_count;

endmodule

// File: rtl/pipeline_stall_sequencer.sv
// Converts ID hazard classes into PC / IF/ID / ID/EX enables, bubbles and flushes.
module pipeline_stall_sequencer
  import pipe_ctrl_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned STALL_W = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ext_hold,
  input  logic             hz_load_use,
  input  logic             hz_br_alu,
  input  logic             hz_br_ld_ex,
  input  logic             hz_br_ld_mem,
  input  logic             redirect,
  input  logic             perf_clr,
  output logic             pc_write_en,
  output logic             ifid_write_en,
  output logic             ifid_flush,
  output logic             idex_write_en,
  output logic             idex_bubble,
  output logic             busy,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_t             r_state;
  state_t             w_state_nxt;
  logic [STALL_W-1:0] r_remaining;
  logic [STALL_W-1:0] w_remaining_nxt;
  logic [STALL_W-1:0] w_len;

  // Stall length of the hazards currently presented by ID.
  always_comb begin
    w_len = STALL_W'(stall_len(hz_load_use, hz_br_alu, hz_br_ld_ex, hz_br_ld_mem));
  end

  // State and stall-remaining registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= RUN;
      r_remaining <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_remaining <= w_remaining_nxt;
    end
  end

  // Next state and same-cycle enables: hold > active stall > new hazard > redirect.
  always_comb begin
    w_state_nxt     = r_state;
    w_remaining_nxt = r_remaining;
    pc_write_en     = 1'b0;
    ifid_write_en   = 1'b0;
    ifid_flush      = 1'b0;
    idex_write_en   = 1'b0;
    idex_bubble     = 1'b0;
    busy            = 1'b0;
    if (!rst) begin
      busy = (r_state == STALL);
      if (ext_hold) begin
        // Everything frozen; state, remaining and counters keep their values.
      end else if (r_state == STALL) begin
        idex_write_en   = 1'b1;
        idex_bubble     = 1'b1;
        w_remaining_nxt = r_remaining - STALL_W'(1);
        if (w_remaining_nxt == '0) begin
          w_state_nxt = RUN;
        end
      end else if (w_len != '0) begin
        // First bubble is issued in the detecting cycle; any redirect waits.
        idex_write_en = 1'b1;
        idex_bubble   = 1'b1;
        if (w_len > STALL_W'(1)) begin
          w_remaining_nxt = w_len - STALL_W'(1);
          w_state_nxt     = STALL;
        end
      end else begin
        pc_write_en   = 1'b1;
        ifid_write_en = 1'b1;
        idex_write_en = 1'b1;
        ifid_flush    = redirect;
      end
    end
  end

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (idex_bubble),
    .count (stall_cycles)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .inc   (ifid_flush),
    .count (flush_count)
  );

endmodule

// File: tb/tb_pipeline_stall_sequencer.sv
// Directed plus randomized bench for pipeline_stall_sequencer against a bubble-debt model.
module tb_pipeline_stall_sequencer;

  localparam int unsigned CNT_W = 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk;
  logic rst, ext_hold, hz_load_use, hz_br_alu, hz_br_ld_ex, hz_br_ld_mem, redirect, perf_clr;
  logic pc_write_en, ifid_write_en, ifid_flush, idex_write_en, idex_bubble, busy;
  logic [CNT_W-1:0] stall_cycles, flush_count;

  int checks;
  int failures;

  // Model: bubbles still owed after the current one, and the two counters.
  int owed;
  int m_stall;
  int m_flush;

  pipeline_stall_sequencer #(.CNT_W(CNT_W), .STALL_W(2)) dut (
    .clk           (clk),
    .rst           (rst),
    .ext_hold      (ext_hold),
    .hz_load_use   (hz_load_use),
    .hz_br_alu     (hz_br_alu),
    .hz_br_ld_ex   (hz_br_ld_ex),
    .hz_br_ld_mem  (hz_br_ld_mem),
    .redirect      (redirect),
    .perf_clr      (perf_clr),
    .pc_write_en   (pc_write_en),
    .ifid_write_en (ifid_write_en),
    .ifid_flush    (ifid_flush),
    .idex_write_en (idex_write_en),
    .idex_bubble   (idex_bubble),
    .busy          (busy),
    .stall_cycles  (stall_cycles),
    .flush_count   (flush_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // One cycle: drive at negedge, check before the posedge, then advance the model.
  task automatic step(input logic r, input logic h, input logic lu, input logic alu,
                      input logic ldex, input logic ldmem, input logic rd, input logic clr);
    int e_pc, e_ifid, e_flush, e_idex, e_bub, e_busy, len;
    @(negedge clk);
    rst = r; ext_hold = h; hz_load_use = lu; hz_br_alu = alu;
    hz_br_ld_ex = ldex; hz_br_ld_mem = ldmem; redirect = rd; perf_clr = clr;
    #1;
    len = ldex ? 2 : ((lu || alu || ldmem) ? 1 : 0);
    e_pc = 0; e_ifid = 0; e_flush = 0; e_idex = 0; e_bub = 0; e_busy = 0;
    if (!r) begin
      e_busy = (owed > 0) ? 1 : 0;
      if (h) begin
        // frozen
      end else if (owed > 0 || len > 0) begin
        e_idex = 1; e_bub = 1;
      end else begin
        e_pc = 1; e_ifid = 1; e_idex = 1; e_flush = rd ? 1 : 0;
      end
    end
    chk("pc_write_en",   int'(pc_write_en),   e_pc);
    chk("ifid_write_en", int'(ifid_write_en), e_ifid);
    chk("ifid_flush",    int'(ifid_flush),    e_flush);
    chk("idex_write_en", int'(idex_write_en), e_idex);
    chk("idex_bubble",   int'(idex_bubble),   e_bub);
    chk("busy",          int'(busy),          e_busy);
    chk("stall_cycles",  int'(stall_cycles),  m_stall);
    chk("flush_count",   int'(flush_count),   m_flush);
    if (r) begin
      owed = 0; m_stall = 0; m_flush = 0;
    end else begin
      if (clr) begin
        m_stall = 0; m_flush = 0;
      end else begin
        if (e_bub == 1 && m_stall < CNT_MAX) m_stall++;
        if (e_flush == 1 && m_flush < CNT_MAX) m_flush++;
      end
      if (!h) begin
        if (owed > 0) owed--;
        else if (len > 0) owed = len - 1;
      end
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    checks = 0; failures = 0; owed = 0; m_stall = 0; m_flush = 0;
    rst = 1'b1; ext_hold = 1'b0; hz_load_use = 1'b0; hz_br_alu = 1'b0;
    hz_br_ld_ex = 1'b0; hz_br_ld_mem = 1'b0; redirect = 1'b0; perf_clr = 1'b0;

    // Reset with hazards pending: all outputs must stay low.
    step(1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    // Single load-use stall.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    // Overlapping 2- and 1-cycle hazards give two bubbles.
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    idle();
    // Redirect alone flushes; redirect with a hazard is ignored.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    // Hold in the middle of a 2-cycle stall.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    idle();
    // Hold in RUN ignores hazards and redirect.
    step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    // Reset in the middle of a stall.
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    // Saturation: 20 load-use stalls on a 4-bit counter.
    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    chk("stall_cycles_saturated", int'(stall_cycles), CNT_MAX);
    // perf_clr beats a same-cycle bubble.
    step(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle();
    chk("stall_cycles_after_clr", int'(stall_cycles), 0);

    // Randomized traffic.
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 59) == 0), ($urandom_range(0, 7) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 5) == 0), ($urandom_range(0, 5) == 0),
           ($urandom_range(0, 3) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
